// File: rtl/add_tree_feeder.sv
// add_tree_feeder: serial-to-parallel window packer for the 26-operand add tree.
// Collects N_TAPS samples, presents them as one packed bus plus a bias word,
// and raises sum_valid when the tree output holds the sum of an accepted window.
// Optional window abort input is enabled with ADD_TREE_FEEDER_ABORT_EN.
module add_tree_feeder #(
  parameter int WIDTH    = 16,
  parameter int N_TAPS   = 25,
  parameter int TREE_LAT = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [WIDTH-1:0]        in_bias,
`ifdef ADD_TREE_FEEDER_ABORT_EN
  input  logic                    in_abort,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH*N_TAPS-1:0] out_bus,
  output logic [WIDTH-1:0]        out_bias,
  output logic                    sum_valid
);

  localparam int CW = $clog2(N_TAPS);
  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_FULL = 1'b1;

  logic [0:0]                         state_q, state_d;
  logic [CW-1:0]                      cnt_q, cnt_d;
  logic [N_TAPS-1:0][WIDTH-1:0]       fill_q, win_d;
  logic [WIDTH-1:0]                   fill_bias_q;
  logic [WIDTH*N_TAPS-1:0]            out_bus_q, out_bus_d;
  logic [WIDTH-1:0]                   out_bias_q, out_bias_d;
  logic                               out_valid_q, out_valid_d;
  logic [TREE_LAT:1]                  vld_pipe_q;

  logic abort, beat, last, out_fire, out_free, load_new, load_pend;

`ifdef ADD_TREE_FEEDER_ABORT_EN
  assign abort = in_abort;
`else
  assign abort = 1'b0;
`endif

  assign in_ready  = (state_q == S_FILL);
  // abort wins over a beat presented in the same cycle
  assign beat      = in_valid && in_ready && !abort;
  assign last      = beat && (cnt_q == CW'(N_TAPS - 1));
  assign out_fire  = out_valid_q && out_ready;
  assign out_free  = !out_valid_q || out_fire;
  // window completing this cycle goes straight to the output register
  assign load_new  = last && out_free;
  // pending complete window moves out as soon as the output register frees
  assign load_pend = (state_q == S_FULL) && out_fire && !abort;

  // completed window as seen this cycle: buffer with the tap-24 beat bypassed in
  always_comb begin
    win_d              = fill_q;
    win_d[N_TAPS-1]    = in_data;
  end

  // FSM, tap counter and output register next state
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_bus_d   = out_bus_q;
    out_bias_d  = out_bias_q;
    out_valid_d = out_valid_q;
    if (abort)
      state_d = S_FILL;
    else if (state_q == S_FILL && last && !out_free)
      state_d = S_FULL;
    else if (load_pend)
      state_d = S_FILL;
    if (abort)
      cnt_d = '0;
    else if (beat)
      cnt_d = last ? '0 : cnt_q + CW'(1);
    if (load_new) begin
      out_bus_d   = win_d;
      out_bias_d  = in_bias;
      out_valid_d = 1'b1;
    end else if (load_pend) begin
      out_bus_d   = fill_q;
      out_bias_d  = fill_bias_q;
      out_valid_d = 1'b1;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  // control, output register and sum-tracking tokens
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_FILL;
      cnt_q       <= '0;
      out_bus_q   <= '0;
      out_bias_q  <= '0;
      out_valid_q <= 1'b0;
      vld_pipe_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_bus_q   <= out_bus_d;
      out_bias_q  <= out_bias_d;
      out_valid_q <= out_valid_d;
      vld_pipe_q  <= {vld_pipe_q[TREE_LAT-1:1], out_fire};
    end
  end

  // fill buffer: pure datapath, overwritten slot by slot so no reset needed
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_TAPS; i++)
      if (beat && cnt_q == CW'(i)) fill_q[i] <= in_data;
    if (last) fill_bias_q <= in_bias;
  end

  assign out_valid = out_valid_q;
  assign out_bus   = out_bus_q;
  assign out_bias  = out_bias_q;
  assign sum_valid = vld_pipe_q[TREE_LAT];

endmodule

// File: tb/tb_add_tree_feeder.sv
`timescale 1ns/1ps
module tb_add_tree_feeder;
  localparam int W = 16, N = 25, L = 5;

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, in_abort = 1'b0;
  logic [W-1:0] in_data = '0, in_bias = '0;
  logic in_ready, out_valid, sum_valid;
  logic [W*N-1:0] out_bus;
  logic [W-1:0] out_bias;

  always #5 clk = ~clk;

  add_tree_feeder #(.WIDTH(W), .N_TAPS(N), .TREE_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_bias(in_bias),
`ifdef ADD_TREE_FEEDER_ABORT_EN
    .in_abort(in_abort),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_bus(out_bus),
    .out_bias(out_bias), .sum_valid(sum_valid)
  );

  int total = 0, bad = 0, cyc = 0, sv_cnt = 0;

  task automatic check(input string nm, input logic [W*N-1:0] act, input logic [W*N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---- behavioural model: windows as lists of samples, one pending slot ----
  logic [W-1:0] part[$];
  int acc_q[$];
  logic m_pend = 1'b0, m_ov = 1'b0, exp_sv = 1'b0;
  logic [W*N-1:0] m_bus = '0, p_bus = '0;
  logic [W-1:0] m_bias = '0, p_bias = '0;

  always @(posedge clk) begin
    logic fire, got;
    logic [W*N-1:0] w;
    logic [W-1:0] wb;
    cyc++;
    got = 1'b0; w = '0; wb = '0; fire = 1'b0;
    if (!rst_n) begin
      part.delete(); acc_q.delete();
      m_pend = 1'b0; m_ov = 1'b0; m_bus = '0; m_bias = '0;
    end else begin
      fire = m_ov && out_ready;
      if (in_abort) begin
        part.delete(); m_pend = 1'b0;
      end else if (in_valid && !m_pend) begin
        part.push_back(in_data);
        if (part.size() == N) begin
          for (int i = 0; i < N; i++) w[i*W +: W] = part[i];
          wb = in_bias; got = 1'b1; part.delete();
        end
      end
      if (fire) acc_q.push_back(cyc);
      if (fire && m_pend) begin
        m_bus = p_bus; m_bias = p_bias; m_pend = 1'b0;
      end else if (got && (!m_ov || fire)) begin
        m_bus = w; m_bias = wb; m_ov = 1'b1;
      end else if (got) begin
        p_bus = w; p_bias = wb; m_pend = 1'b1;
      end else if (fire) begin
        m_ov = 1'b0;
      end
    end
    // sum appears TREE_LAT clocks after the acceptance cycle
    exp_sv = (acc_q.size() > 0 && acc_q[0] == cyc - (L - 1));
    if (exp_sv) void'(acc_q.pop_front());
  end

  // ---- compare process ----
  always @(negedge clk) begin
    check("in_ready", {399'b0, in_ready}, {399'b0, !m_pend});
    check("out_valid", {399'b0, out_valid}, {399'b0, m_ov});
    check("out_bus", out_bus, m_bus);
    check("out_bias", {384'b0, out_bias}, {384'b0, m_bias});
    check("sum_valid", {399'b0, sum_valid}, {399'b0, exp_sv});
    if (sum_valid) sv_cnt++;
  end

  // ---- driver ----
  logic [W-1:0] wd[N];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input logic [W-1:0] d, input logic [W-1:0] b);
    bit ok;
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d; in_bias = b;
    do begin ok = in_ready; tick(); n++; end while (!ok && n < 200);
    if (!ok) check("beat_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_beats(input int from, input int to, input logic [W-1:0] b);
    for (int i = from; i <= to; i++) send_beat(wd[i], b);
  endtask

  function automatic int slot(input int i);
    return int'(out_bus[i*W +: W]);
  endfunction

  initial begin
    int s, sv0;
    logic [W*N-1:0] all;
    repeat (3) tick();
    rst_n = 1'b1;
    check("reset_bus", out_bus, 0);
    check("reset_ready", in_ready, 1);

    // single window 1..25, bias 0x64
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) wd[i] = W'(i + 1);
    send_beats(0, N - 1, 16'h0064);
    check("w1_valid", out_valid, 1);
    check("w1_slot0", slot(0), 16'h0001);
    check("w1_slot24", slot(24), 16'h0019);
    check("w1_bias", out_bias, 16'h0064);
    s = int'(out_bias);
    for (int i = 0; i < N; i++) s += slot(i);
    check("w1_treesum", s, 32'h01A9);
    repeat (4) tick();
    check("w1_sum_early", sum_valid, 0);
    tick();
    check("w1_sum_at5", sum_valid, 1);
    tick();
    check("w1_sum_once", sum_valid, 0);

    // three windows back to back
    sv0 = sv_cnt;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < N; i++) wd[i] = W'($urandom);
      send_beats(0, N - 1, W'($urandom));
    end
    repeat (8) tick();
    check("b2b_sums", sv_cnt - sv0, 3);

    // backpressure: window 1 held, window 2 pends
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) wd[i] = W'(16'h0100 + i);
    send_beats(0, N - 1, 16'h0011);
    for (int i = 0; i < N; i++) wd[i] = W'(16'h0200 + i);
    send_beats(0, N - 1, 16'h0022);
    check("bp_full_ready", in_ready, 0);
    check("bp_hold_bus", slot(0), 16'h0100);
    repeat (3) tick();
    check("bp_still_full", in_ready, 0);
    out_ready = 1'b1;
    tick();
    check("bp_load_w2", slot(0), 16'h0200);
    check("bp_bias_w2", out_bias, 16'h0022);
    check("bp_ready_back", in_ready, 1);
    repeat (8) tick();

    // reset mid-fill
    for (int i = 0; i < N; i++) wd[i] = W'(16'h0777);
    send_beats(0, 11, 16'h0001);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_ov", out_valid, 0);
    check("rst_sv", sum_valid, 0);
    for (int i = 0; i < N; i++) wd[i] = 16'h0002;
    send_beats(0, N - 1, 16'h0005);
    all = {N{16'h0002}};
    check("rst_clean_bus", out_bus, all);
    repeat (8) tick();

    // tap-24 beat coincides with acceptance of the previous window
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) wd[i] = W'(16'h0A00 + i);
    send_beats(0, N - 1, 16'h0033);
    for (int i = 0; i < N; i++) wd[i] = W'(16'h0B00 + i);
    send_beats(0, N - 2, 16'h0044);
    out_ready = 1'b1;
    send_beat(wd[N-1], 16'h0044);
    check("same_ov", out_valid, 1);
    check("same_bus", slot(24), 16'h0B18);
    tick();
    check("same_drop", out_valid, 0);
    repeat (3) tick();
    check("same_sum_a", sum_valid, 1);
    tick();
    check("same_sum_b", sum_valid, 1);
    tick();
    check("same_sum_end", sum_valid, 0);
    repeat (4) tick();

`ifdef ADD_TREE_FEEDER_ABORT_EN
    for (int i = 0; i < N; i++) wd[i] = W'(16'h0900 + i);
    send_beats(0, 9, 16'h0001);
    in_abort = 1'b1;
    tick();
    in_abort = 1'b0;
    sv0 = sv_cnt;
    for (int i = 0; i < N; i++) wd[i] = 16'h0003;
    send_beats(0, N - 1, 16'h0006);
    all = {N{16'h0003}};
    check("abort_bus", out_bus, all);
    repeat (8) tick();
    check("abort_one_sum", sv_cnt - sv0, 1);
`endif

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 8);
      in_data   = W'($urandom);
      in_bias   = W'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      rst_n     = ($urandom_range(0, 399) != 0);
`ifdef ADD_TREE_FEEDER_ABORT_EN
      in_abort  = ($urandom_range(0, 59) == 0);
`endif
      tick();
    end
    in_valid = 1'b0; in_abort = 1'b0; rst_n = 1'b1; out_ready = 1'b1;
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
